// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts whole seconds down from GAME_SECONDS in BCD, driven by tick pulses.
// Latency: state/digits update on the edge that samples tick/start/stop/add_bonus; visible one cycle later.
// Backpressure: none; all control inputs are single-cycle pulses except pause, which is a hold level.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              1-cycle pulse, TICKS_PER_SEC of these make one second
//   start / stop      1-cycle pulses: (re)start the round / abort to idle
//   pause             level: freeze the countdown while high
//   add_bonus         1-cycle pulse: add BONUS_SECONDS (saturating at 99)
//   sec_tens/sec_ones remaining seconds as two BCD digits
//   running           high only while actively counting
//   time_up           1-cycle pulse on the cycle the digits first show 00
module game_countdown_timer #(
  parameter int GAME_SECONDS  = 60,
  parameter int TICKS_PER_SEC = 10,
  parameter int BONUS_SECONDS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       add_bonus,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       time_up
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] INIT_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] INIT_ONES = 4'(GAME_SECONDS % 10);
  localparam logic [7:0] SUB_LAST  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] BONUS_VAL = 8'(BONUS_SECONDS);

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [7:0] sub_q, sub_d;
  logic       running_q, running_d;
  logic       time_up_q, time_up_d;

  logic [7:0] val_cur;
  logic [7:0] val_nxt;
  logic       sec_dec;

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    sub_d     = sub_q;
    time_up_d = 1'b0;
    sec_dec   = 1'b0;
    // Arithmetic is done on the binary value of the two digits; the result
    // is split back into BCD, which keeps borrow and saturation trivial.
    val_cur   = {4'd0, tens_q} * 8'd10 + {4'd0, ones_q};
    val_nxt   = val_cur;

    if (stop) begin
      state_d = ST_IDLE;
      tens_d  = INIT_TENS;
      ones_d  = INIT_ONES;
      sub_d   = 8'd0;
    end else if (start) begin
      state_d = ST_RUN;
      tens_d  = INIT_TENS;
      ones_d  = INIT_ONES;
      sub_d   = 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            if (tick) begin
              if (sub_q == SUB_LAST) begin
                sub_d   = 8'd0;
                sec_dec = 1'b1;
              end else begin
                sub_d = sub_q + 8'd1;
              end
            end
            // The value is never 00 while running, so the decrement cannot wrap.
            val_nxt = val_cur - {7'd0, sec_dec} + (add_bonus ? BONUS_VAL : 8'd0);
            if (val_nxt > 8'd99) begin
              val_nxt = 8'd99;
            end
            tens_d = 4'(val_nxt / 8'd10);
            ones_d = 4'(val_nxt % 8'd10);
            if (val_nxt == 8'd0) begin
              state_d   = ST_DONE;
              time_up_d = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          // IDLE and DONE hold everything until start/stop.
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tens_q    <= INIT_TENS;
      ones_q    <= INIT_ONES;
      sub_q     <= 8'd0;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      sub_q     <= sub_d;
      running_q <= running_d;
      time_up_q <= time_up_d;
    end
  end

  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign running  = running_q;
  assign time_up  = time_up_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
module tb_game_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       tick, start, stop, pause, add_bonus;
  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic       a_run, a_tu, b_run, b_tu;

  int total = 0;
  int bad   = 0;

  // Short round used for most checks.
  game_countdown_timer #(.GAME_SECONDS(3), .TICKS_PER_SEC(2), .BONUS_SECONDS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .add_bonus(add_bonus),
    .sec_tens(a_tens), .sec_ones(a_ones), .running(a_run), .time_up(a_tu)
  );

  // Long round used for saturation and tens borrow.
  game_countdown_timer #(.GAME_SECONDS(97), .TICKS_PER_SEC(2), .BONUS_SECONDS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .add_bonus(add_bonus),
    .sec_tens(b_tens), .sec_ones(b_ones), .running(b_run), .time_up(b_tu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining time as a plain integer number of seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  typedef struct {
    int mode;
    int secs;
    int sub;
    bit tu;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_init(input int gs);
    mdl_t r;
    r.mode = M_IDLE; r.secs = gs; r.sub = 0; r.tu = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int gs, input int tps, input int bon,
                                    input bit sp, input bit st, input bit pa, input bit tk, input bit bo);
    mdl_t r;
    int s;
    r = m;
    r.tu = 0;
    s = m.secs;
    if (sp) begin
      r.mode = M_IDLE; r.secs = gs; r.sub = 0;
    end else if (st) begin
      r.mode = M_RUN; r.secs = gs; r.sub = 0;
    end else if (m.mode == M_RUN) begin
      if (pa) begin
        r.mode = M_PAUSED;
      end else begin
        if (tk) begin
          r.sub = m.sub + 1;
          if (r.sub == tps) begin
            r.sub = 0;
            s = s - 1;
          end
        end
        if (bo) s = s + bon;
        if (s > 99) s = 99;
        r.secs = s;
        if (s == 0) begin
          r.mode = M_DONE;
          r.tu = 1;
        end
      end
    end else if (m.mode == M_PAUSED && !pa) begin
      r.mode = M_RUN;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_mdl(input string tag, input logic [3:0] t, input logic [3:0] o,
                         input logic r, input logic u, input mdl_t m);
    chk({tag, "_digits"}, {24'd0, t, o}, (m.secs / 10) * 16 + (m.secs % 10));
    chk({tag, "_running"}, int'(r), (m.mode == M_RUN) ? 1 : 0);
    chk({tag, "_time_up"}, int'(u), int'(m.tu));
  endtask

  // One clock cycle: drive inputs, advance on the edge, then compare both
  // instances against their models a little after the edge.
  task automatic cyc(input bit sp, input bit st, input bit pa, input bit tk, input bit bo);
    stop = sp; start = st; pause = pa; tick = tk; add_bonus = bo;
    @(posedge clk);
    #1;
    ma = mdl_step(ma, 3, 2, 5, sp, st, pa, tk, bo);
    mb = mdl_step(mb, 97, 2, 5, sp, st, pa, tk, bo);
    chk_mdl("a", a_tens, a_ones, a_run, a_tu, ma);
    chk_mdl("b", b_tens, b_ones, b_run, b_tu, mb);
  endtask

  typedef struct {
    bit       sp, st, pa, tk, bo;
    bit [3:0] tens, ones;
    bit       run, tu;
  } vec_t;

  vec_t tbl[$];
  bit   pa_lvl;

  initial begin
    // {stop, start, pause, tick, bonus, tens, ones, running, time_up}
    // Full round: two ticks per second, 3 -> 0.
    tbl.push_back('{0,1,0,0,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,1, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,1, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,0, 0,1});
    tbl.push_back('{0,0,0,0,0, 0,0, 0,0});
    tbl.push_back('{0,0,0,1,1, 0,0, 0,0});
    // Pause holds 02 through ticks and bonus; resume finishes on the 6th counted tick.
    tbl.push_back('{0,1,0,0,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    tbl.push_back('{0,0,1,1,0, 0,2, 0,0});
    tbl.push_back('{0,0,1,1,1, 0,2, 0,0});
    tbl.push_back('{0,0,1,1,0, 0,2, 0,0});
    tbl.push_back('{0,0,0,0,0, 0,2, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,1, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,1, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,0, 0,1});
    // Bonus on the final second-decrement rescues the round: 1 - 1 + 5 = 5.
    tbl.push_back('{0,1,0,0,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,1, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,1, 1,0});
    tbl.push_back('{0,0,0,1,1, 0,5, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,5, 1,0});
    // stop beats start; start reloads and clears the sub-tick count, ignoring its own tick.
    tbl.push_back('{1,1,0,1,1, 0,3, 0,0});
    tbl.push_back('{0,1,0,1,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,3, 1,0});
    tbl.push_back('{0,0,0,1,0, 0,2, 1,0});
    // start beats pause in the same cycle; pause takes effect the cycle after.
    tbl.push_back('{0,1,1,0,0, 0,3, 1,0});
    tbl.push_back('{0,0,1,0,0, 0,3, 0,0});
    tbl.push_back('{0,0,0,0,0, 0,3, 1,0});
    tbl.push_back('{1,0,0,0,0, 0,3, 0,0});

    stop = 0; start = 0; pause = 0; tick = 0; add_bonus = 0;
    rst_n = 1'b0;
    ma = mdl_init(3);
    mb = mdl_init(97);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_digits", {24'd0, a_tens, a_ones}, 'h03);
    chk("rst_a_running", int'(a_run), 0);
    chk("rst_a_time_up", int'(a_tu), 0);
    chk("rst_b_digits", {24'd0, b_tens, b_ones}, 'h97);
    rst_n = 1'b1;

    // Ticks, pause and bonus in IDLE do nothing.
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].sp, tbl[i].st, tbl[i].pa, tbl[i].tk, tbl[i].bo);
      chk($sformatf("tbl%0d_digits", i), {24'd0, a_tens, a_ones}, {24'd0, tbl[i].tens, tbl[i].ones});
      chk($sformatf("tbl%0d_running", i), int'(a_run), int'(tbl[i].run));
      chk($sformatf("tbl%0d_time_up", i), int'(a_tu), int'(tbl[i].tu));
    end

    // Saturation at 99 and ones-digit borrow on the long round.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("sat_99", {24'd0, b_tens, b_ones}, 'h99);
    repeat (2) cyc(0, 0, 0, 1, 0);
    chk("after_sat_98", {24'd0, b_tens, b_ones}, 'h98);
    repeat (16) cyc(0, 0, 0, 1, 0);
    chk("reach_90", {24'd0, b_tens, b_ones}, 'h90);
    cyc(0, 0, 0, 1, 0);
    chk("hold_90", {24'd0, b_tens, b_ones}, 'h90);
    cyc(0, 0, 0, 1, 0);
    chk("borrow_89", {24'd0, b_tens, b_ones}, 'h89);

    // Asynchronous reset in the middle of a round, asserted between edges.
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_a_digits", {24'd0, a_tens, a_ones}, 'h03);
    chk("arst_a_running", int'(a_run), 0);
    chk("arst_a_time_up", int'(a_tu), 0);
    chk("arst_b_digits", {24'd0, b_tens, b_ones}, 'h97);
    chk("arst_b_running", int'(b_run), 0);
    ma = mdl_init(3);
    mb = mdl_init(97);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Restart after reset: full sub-tick period needed before the first decrement.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("post_rst_sub_cleared", {24'd0, a_tens, a_ones}, 'h03);

    // Randomized traffic against the model.
    pa_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) pa_lvl = ~pa_lvl;
      cyc($urandom_range(63) == 0, $urandom_range(23) == 0, pa_lvl,
          $urandom_range(1) == 0, $urandom_range(11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
